// File: rtl/bmem_pkg.sv
// bmem_pkg: shared widths and adapter state encoding for the bmem line adapter
package bmem_pkg;
    localparam int BEAT_WIDTH = 64;
    localparam int BURST_LEN = 4;
    localparam int LINE_WIDTH = BEAT_WIDTH * BURST_LEN;
    localparam int LINE_OFFSET_BITS = 5;
    localparam int CNT_WIDTH = $clog2(BURST_LEN);
    typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_BURST, RESP} adapter_state_t;
endpackage

// File: rtl/bmem_beat_shifter.sv
// bmem_beat_shifter: cacheline register with a beat-indexed write port and beat-indexed read mux
module bmem_beat_shifter
    import bmem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  store,
    input  logic [LINE_WIDTH-1:0] load_line,
    input  logic [CNT_WIDTH-1:0]  idx,
    input  logic [BEAT_WIDTH-1:0] beat_in,
    output logic [LINE_WIDTH-1:0] line,
    output logic [BEAT_WIDTH-1:0] beat_out
);
    // whole-line load for writes, single-beat store for returning read beats
    always_ff @(posedge clk)
        if (rst) line <= '0;
        else if (load) line <= load_line;
        else if (store) line[int'(idx) * BEAT_WIDTH +: BEAT_WIDTH] <= beat_in;
    assign beat_out = line[int'(idx) * BEAT_WIDTH +: BEAT_WIDTH];
endmodule

// File: rtl/bmem_line_adapter.sv
// bmem_line_adapter: turns one 256-bit cacheline request into a 4-beat bmem burst
module bmem_line_adapter
    import bmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic [LINE_WIDTH-1:0] dfp_rdata,
    output logic                  dfp_resp,
    output logic [ADDR_WIDTH-1:0] bmem_addr,
    output logic                  bmem_read,
    output logic                  bmem_write,
    output logic [BEAT_WIDTH-1:0] bmem_wdata,
    input  logic                  bmem_ready,
    input  logic [ADDR_WIDTH-1:0] bmem_raddr,
    input  logic [BEAT_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid,
    output logic                  proto_err
);
    adapter_state_t state, state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [LINE_WIDTH-1:0] line;
    logic [BEAT_WIDTH-1:0] beat_out;
    logic last_beat, rd_store, wr_xfer, err;
    logic [1:0] unused_bits;

    assign last_beat = cnt == CNT_WIDTH'(BURST_LEN - 1);
    assign rd_store = state == RD_DATA && bmem_rvalid && bmem_raddr == bmem_addr;
    assign wr_xfer = state == WR_BURST && bmem_ready;
    assign err = (state == IDLE && dfp_read && dfp_write)
               || (bmem_rvalid && (state == IDLE || state == RD_CMD || state == WR_BURST))
               || (state == RD_DATA && bmem_rvalid && bmem_raddr != bmem_addr);
    // offset bits are dropped by line alignment; the top beat is taken straight from bmem_rdata
    assign unused_bits = {^dfp_addr[LINE_OFFSET_BITS-1:0], ^line[LINE_WIDTH-1 -: BEAT_WIDTH]};

    bmem_beat_shifter u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (state == IDLE && dfp_write),
        .store    (rd_store),
        .load_line(dfp_wdata),
        .idx      (cnt),
        .beat_in  (bmem_rdata),
        .line     (line),
        .beat_out (beat_out)
    );

    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_next;

    // next state: write wins over read, bursts end on the last accepted beat
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     state_next = dfp_write ? WR_BURST : dfp_read ? RD_CMD : IDLE;
            RD_CMD:   state_next = bmem_ready ? RD_DATA : RD_CMD;
            RD_DATA:  state_next = rd_store && last_beat ? RESP : RD_DATA;
            WR_BURST: state_next = wr_xfer && last_beat ? RESP : WR_BURST;
            default:  state_next = IDLE;
        endcase
    end

    // bus outputs decoded from state
    always_comb begin
        bmem_read = state == RD_CMD;
        bmem_write = state == WR_BURST;
        bmem_wdata = state == WR_BURST ? beat_out : '0;
        dfp_resp = state == RESP;
    end

    // line address, beat counter, completed read line and sticky protocol error
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            bmem_addr <= '0;
            dfp_rdata <= '0;
            proto_err <= 1'b0;
        end else begin
            if (state == IDLE && (dfp_read || dfp_write))
                bmem_addr <= {dfp_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
            if (state == IDLE || (state == RD_CMD && bmem_ready)) cnt <= '0;
            else if (rd_store || wr_xfer) cnt <= cnt + 1'b1;
            if (rd_store && last_beat)
                dfp_rdata <= {bmem_rdata, line[LINE_WIDTH-BEAT_WIDTH-1:0]};
            if (err) proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bmem_line_adapter.sv
// tb_bmem_line_adapter: directed read/write bursts against bmem_line_adapter
module tb_bmem_line_adapter;
    logic         clk, rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read, dfp_write;
    logic [255:0] dfp_wdata, dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read, bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;
    logic         proto_err;

    int checks = 0;
    int failures = 0;
    int rd_cycles = 0;
    int resp_cnt = 0;
    logic [63:0] wq[$];
    logic [63:0] bt[4];
    logic [63:0] eb[4];

    bmem_line_adapter dut (
        .clk        (clk),
        .rst        (rst),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_write  (dfp_write),
        .dfp_wdata  (dfp_wdata),
        .dfp_rdata  (dfp_rdata),
        .dfp_resp   (dfp_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid),
        .proto_err  (proto_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // mid-cycle monitor: accepted write beats, read-command cycles, response pulses
    always @(negedge clk) begin
        if (bmem_write && bmem_ready) wq.push_back(bmem_wdata);
        if (bmem_read) rd_cycles++;
        if (dfp_resp) resp_cnt++;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string t);
        chk({t, "_resp"}, dfp_resp, 0);
        chk({t, "_rdata"}, dfp_rdata, 0);
        chk({t, "_bread"}, bmem_read, 0);
        chk({t, "_bwrite"}, bmem_write, 0);
        chk({t, "_baddr"}, bmem_addr, 0);
        chk({t, "_bwdata"}, bmem_wdata, 0);
        chk({t, "_perr"}, proto_err, 0);
    endtask

    task automatic write_txn(input string t, input logic [31:0] addr, input logic [255:0] wl,
                             input int s1, input int s2, input logic both, input logic [31:0] eaddr);
        int st[4];
        st = '{0, s1, s2, 0};
        wq.delete();
        dfp_addr = addr;
        dfp_wdata = wl;
        dfp_write = 1;
        dfp_read = both;
        bmem_ready = 1;
        step();
        chk({t, "_addr"}, bmem_addr, eaddr);
        for (int b = 0; b < 4; b++) begin
            bmem_ready = 0;
            for (int i = 0; i < st[b]; i++) begin
                step();
                chk({t, "_hold"}, {bmem_write, bmem_wdata, bmem_addr}, {1'b1, eb[b], eaddr});
            end
            bmem_ready = 1;
            if (b == 3) chk({t, "_early_resp"}, dfp_resp, 0);
            step();
        end
        chk({t, "_resp"}, dfp_resp, 1);
        chk({t, "_wdrop"}, bmem_write, 0);
        dfp_write = 0;
        dfp_read = 0;
        step();
        chk({t, "_resp_pulse"}, dfp_resp, 0);
        chk({t, "_nbeats"}, wq.size(), 4);
        for (int i = 0; i < 4 && i < wq.size(); i++) chk({t, "_beat"}, wq[i], eb[i]);
    endtask

    task automatic read_txn(input string t, input logic [31:0] addr, input logic [31:0] eaddr,
                            input int rw, input int exp_rd, input int lat, input int gap,
                            input logic bad, input int rst_at, input logic [255:0] eline);
        int r0;
        rd_cycles = 0;
        dfp_addr = addr;
        dfp_read = 1;
        bmem_ready = 0;
        bmem_rvalid = 0;
        step();
        chk({t, "_addr"}, bmem_addr, eaddr);
        chk({t, "_cmd"}, bmem_read, 1);
        repeat (rw) step();
        bmem_ready = 1;
        step();
        bmem_ready = 0;
        chk({t, "_cmd_drop"}, bmem_read, 0);
        repeat (lat) step();
        for (int b = 0; b < 4; b++) begin
            if (b == rst_at) begin
                bmem_rvalid = 0;
                dfp_read = 0;
                rst = 1;
                step();
                rst = 0;
                r0 = resp_cnt;
                chk_reset_outputs({t, "_rst"});
                repeat (3) step();
                chk({t, "_no_resp"}, resp_cnt, r0);
                return;
            end
            if (bad && b == 1) begin
                bmem_rvalid = 1;
                bmem_raddr = 32'h0000_2000;
                bmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
                step();
            end
            if (b > 0) begin
                bmem_rvalid = 0;
                repeat (gap) step();
            end
            bmem_rvalid = 1;
            bmem_raddr = eaddr;
            bmem_rdata = bt[b];
            if (b == 3) chk({t, "_early_resp"}, dfp_resp, 0);
            step();
        end
        bmem_rvalid = 0;
        chk({t, "_resp"}, dfp_resp, 1);
        chk({t, "_line"}, dfp_rdata, eline);
        dfp_read = 0;
        step();
        chk({t, "_resp_pulse"}, dfp_resp, 0);
        chk({t, "_cmd_cycles"}, rd_cycles, exp_rd);
    endtask

    initial begin
        rst = 1;
        dfp_addr = 0;
        dfp_read = 0;
        dfp_write = 0;
        dfp_wdata = 0;
        bmem_ready = 0;
        bmem_raddr = 0;
        bmem_rdata = 0;
        bmem_rvalid = 0;
        repeat (3) step();
        rst = 0;
        chk_reset_outputs("reset");

        bt = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        read_txn("rd1", 32'h1234_5678, 32'h1234_5660, 0, 1, 7, 0, 0, -1,
                 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
        chk("rd1_perr", proto_err, 0);

        eb = '{64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
               64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        write_txn("wr1", 32'h0000_1000,
                  256'hAAAAAAAAAAAAAAAA_BBBBBBBBBBBBBBBB_CCCCCCCCCCCCCCCC_DDDDDDDDDDDDDDDD,
                  0, 0, 0, 32'h0000_1000);
        chk("wr1_rdata_kept", dfp_rdata,
            256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

        eb = '{64'h1, 64'h2, 64'h3, 64'h4};
        write_txn("wr_stall", 32'h0000_201F,
                  256'h0000000000000004_0000000000000003_0000000000000002_0000000000000001,
                  3, 3, 0, 32'h0000_2000);
        chk("wr_stall_perr", proto_err, 0);

        eb = '{64'h0123_4567_89AB_CDEF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001};
        write_txn("wr_both", 32'h0000_4010,
                  256'h8000000000000001_FFFFFFFFFFFFFFFF_0000000000000000_0123456789ABCDEF,
                  0, 0, 1, 32'h0000_4000);
        chk("wr_both_perr", proto_err, 1);

        rst = 1;
        step();
        rst = 0;
        chk("rst2_perr", proto_err, 0);

        bt = '{64'hA0A0_A0A0_A0A0_A0A0, 64'hB1B1_B1B1_B1B1_B1B1,
               64'hC2C2_C2C2_C2C2_C2C2, 64'hD3D3_D3D3_D3D3_D3D3};
        read_txn("rd_bad", 32'h0000_3047, 32'h0000_3040, 5, 6, 3, 2, 1, -1,
                 256'hD3D3D3D3D3D3D3D3_C2C2C2C2C2C2C2C2_B1B1B1B1B1B1B1B1_A0A0A0A0A0A0A0A0);
        chk("rd_bad_perr", proto_err, 1);

        bt = '{64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
               64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404};
        read_txn("rd_rst", 32'h0000_5000, 32'h0000_5000, 0, 1, 2, 0, 0, 2, 256'h0);

        bt = '{64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
               64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888};
        read_txn("rd_fresh", 32'hFFFF_FFE3, 32'hFFFF_FFE0, 0, 1, 4, 1, 0, -1,
                 256'h8888888888888888_7777777777777777_6666666666666666_5555555555555555);
        chk("rd_fresh_perr", proto_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
